pll_lock_sequencer: RTL and testbench



---
 rtl/pll_lock_sequencer.sv | 162 ++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//   Supervises the PLL that makes the processor clock. It pulses the PLL
//   reset, waits for lock, and requires lock to stay continuously high for
//   STABLE_CYCLES before it releases the core. A lock loss in RUN, or a
//   lock timeout, re-runs the PLL reset. After RELOCK_RETRIES failed
//   retries it parks in a sticky FAULT until soft_relock is pulsed.
//
// Ports
//   clk          raw oscillator clock
//   reset        synchronous, active-high
//   lock         PLL LOCK, asynchronous to clk
//   soft_relock  single-cycle request to re-run the sequence (RUN/FAULT only)
//   pll_resetb   PLL RESETB, active low
//   core_reset   active-high reset to the core (low only in RUN)
//   ready        inverse of core_reset
//   fault        sticky: every lock attempt failed
//   retry_count  failed attempts since the last RUN entry, saturates at 3
module pll_lock_sequencer #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 4096,
  parameter int STABLE_CYCLES  = 1024,
  parameter int RELOCK_RETRIES = 3,
  parameter int CNT_W          = 13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lock,
  input  logic       soft_relock,
  output logic       pll_resetb,
  output logic       core_reset,
  output logic       ready,
  output logic       fault,
  output logic [1:0] retry_count
);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retry_q, retry_d;
  logic             lock_meta_q, lock_s_q;
  logic             pll_resetb_q, pll_resetb_d;
  logic             core_reset_q, core_reset_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;
  logic             retries_spent;

  // Zero-extend the 2-bit count so a RELOCK_RETRIES above 3 never matches:
  // the count then saturates and the block keeps retrying.
  assign retries_spent = (32'(retry_q) == 32'(RELOCK_RETRIES));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    case (state_q)
      S_PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          cnt_d = '0;
          if (retries_spent) begin
            state_d = S_FAULT;
          end else begin
            state_d = S_PLL_RST;
            if (retry_q != 2'd3) retry_d = retry_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_STABLE: begin
        // A lock drop here is a glitch, not a failed attempt.
        if (!lock_s_q) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STB_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
          retry_d = 2'd0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_RUN: begin
        // Lock loss and soft_relock together still produce one PLL_RST entry.
        if (!lock_s_q || soft_relock) begin
          state_d = S_PLL_RST;
          cnt_d   = '0;
        end
      end
      S_FAULT: begin
        if (soft_relock) begin
          state_d = S_PLL_RST;
          cnt_d   = '0;
          retry_d = 2'd0;
        end
      end
      default: begin
        state_d = S_PLL_RST;
        cnt_d   = '0;
      end
    endcase

    // Outputs decode the state being entered so they move with the state.
    pll_resetb_d = (state_d != S_PLL_RST);
    core_reset_d = (state_d != S_RUN);
    ready_d      = (state_d == S_RUN);
    fault_d      = (state_d == S_FAULT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_PLL_RST;
      cnt_q        <= '0;
      retry_q      <= 2'd0;
      lock_meta_q  <= 1'b0;
      lock_s_q     <= 1'b0;
      pll_resetb_q <= 1'b0;
      core_reset_q <= 1'b1;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      lock_meta_q  <= lock;
      lock_s_q     <= lock_meta_q;
      pll_resetb_q <= pll_resetb_d;
      core_reset_q <= core_reset_d;
      ready_q      <= ready_d;
      fault_q      <= fault_d;
    end
  end

  assign pll_resetb  = pll_resetb_q;
  assign core_reset  = core_reset_q;
  assign ready       = ready_q;
  assign fault       = fault_q;
  assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed scenarios with literal expectations
// followed by a randomized phase, all checked every cycle against a
// behavioural model that tracks the current phase and the edge on which it
// was entered (dwell time = edges elapsed since entry).
module tb_pll_lock_sequencer;
  localparam int PRC = 4;
  localparam int LTO = 16;
  localparam int STB = 8;
  localparam int RR  = 2;
  localparam int CW  = 5;

  localparam int PH_RST  = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_STB  = 2;
  localparam int PH_RUN  = 3;
  localparam int PH_FLT  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       lock = 1'b0;
  logic       soft_relock = 1'b0;
  logic       pll_resetb, core_reset, ready, fault;
  logic [1:0] retry_count;

  int n_cmp = 0;
  int n_bad = 0;

  pll_lock_sequencer #(
    .PLL_RST_CYCLES(PRC), .LOCK_TIMEOUT(LTO), .STABLE_CYCLES(STB),
    .RELOCK_RETRIES(RR), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .lock(lock), .soft_relock(soft_relock),
    .pll_resetb(pll_resetb), .core_reset(core_reset), .ready(ready),
    .fault(fault), .retry_count(retry_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int cyc = 0;
  int m_phase = PH_RST;
  int m_enter = 0;
  int m_retry = 0;
  bit m_sync1 = 1'b0, m_sync2 = 1'b0;
  bit m_valid = 1'b0;

  function automatic void go(input int p);
    m_phase = p;
    m_enter = cyc;
  endfunction

  always @(posedge clk) begin : model
    int el;
    bit ls;
    cyc++;
    ls = m_sync2;
    if (reset) begin
      m_valid = 1'b1;
      m_retry = 0;
      go(PH_RST);
      m_sync1 = 1'b0;
      m_sync2 = 1'b0;
    end else begin
      el = cyc - m_enter;
      case (m_phase)
        PH_RST:  if (el == PRC) go(PH_WAIT);
        PH_WAIT: begin
          if (ls) go(PH_STB);
          else if (el == LTO) begin
            if (m_retry == RR) go(PH_FLT);
            else begin
              m_retry = (m_retry + 1 > 3) ? 3 : m_retry + 1;
              go(PH_RST);
            end
          end
        end
        PH_STB: begin
          if (!ls) go(PH_WAIT);
          else if (el == STB) begin
            m_retry = 0;
            go(PH_RUN);
          end
        end
        PH_RUN:  if (!ls || soft_relock) go(PH_RST);
        PH_FLT:  if (soft_relock) begin
          m_retry = 0;
          go(PH_RST);
        end
        default: go(PH_RST);
      endcase
      m_sync2 = m_sync1;
      m_sync1 = lock;
    end
    #1;
    if (m_valid) begin
      chk("m_pll_resetb", 32'(pll_resetb), 32'(m_phase != PH_RST));
      chk("m_core_reset", 32'(core_reset), 32'(m_phase != PH_RUN));
      chk("m_ready",      32'(ready),      32'(m_phase == PH_RUN));
      chk("m_fault",      32'(fault),      32'(m_phase == PH_FLT));
      chk("m_retry",      32'(retry_count), 32'(m_retry));
    end
  end

  // ---------------- stimulus ----------------
  // edges(n): advance n rising edges, land 2 time units after the last one.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Holds reset over two edges; on return the next edge is E1 of the run.
  task automatic do_reset(input logic lk);
    @(negedge clk);
    reset = 1'b1;
    lock = lk;
    soft_relock = 1'b0;
    edges(2);
    chk("rst_pll_resetb", 32'(pll_resetb), 32'd0);
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_ready", 32'(ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    // Test 1: lock high from the start.
    do_reset(1'b1);
    edges(3);  chk("t1_pllrst_e3", 32'(pll_resetb), 32'd0);
    edges(1);  chk("t1_pllrst_e4", 32'(pll_resetb), 32'd1);
               chk("t1_ready_e4", 32'(ready), 32'd0);
    edges(8);  chk("t1_ready_e12", 32'(ready), 32'd0);
    edges(1);  chk("t1_ready_e13", 32'(ready), 32'd1);
               chk("t1_core_e13", 32'(core_reset), 32'd0);
               chk("t1_retry_e13", 32'(retry_count), 32'd0);

    // Test 4: lock drops in RUN, reset shows 3 edges after the pin drop.
    @(negedge clk); lock = 1'b0;
    edges(2);  chk("t4_ready_2e", 32'(ready), 32'd1);
    edges(1);  chk("t4_ready_3e", 32'(ready), 32'd0);
               chk("t4_core_3e", 32'(core_reset), 32'd1);
               chk("t4_pll_3e", 32'(pll_resetb), 32'd0);
    @(negedge clk); lock = 1'b1;
    edges(40); chk("t4_ready_reseq", 32'(ready), 32'd1);

    // Test 5a: soft_relock in RUN.
    @(negedge clk); soft_relock = 1'b1;
    edges(1);  chk("t5_soft_pll", 32'(pll_resetb), 32'd0);
               chk("t5_soft_ready", 32'(ready), 32'd0);
    @(negedge clk); soft_relock = 1'b0;

    // Test 6a: reset while in RUN.
    edges(20); chk("t6_run_ready", 32'(ready), 32'd1);
    @(negedge clk); reset = 1'b1;
    edges(1);  chk("t6_run_pll", 32'(pll_resetb), 32'd0);
               chk("t6_run_ready0", 32'(ready), 32'd0);
    edges(1);
    @(negedge clk); reset = 1'b0;

    // Test 3: lock glitch in STABLE at cnt=5 (E5 entry, E10 -> cnt 5).
    edges(10);
    @(negedge clk); lock = 1'b0;
    edges(3);  chk("t3_ready_e13", 32'(ready), 32'd0);
               chk("t3_retry_e13", 32'(retry_count), 32'd0);
               chk("t3_pll_e13", 32'(pll_resetb), 32'd1);
    @(negedge clk); lock = 1'b1;
    edges(10); chk("t3_ready_e23", 32'(ready), 32'd0);
    edges(1);  chk("t3_ready_e24", 32'(ready), 32'd1);

    // Test 2: lock never comes.
    do_reset(1'b0);
    edges(20); chk("t2_retry1", 32'(retry_count), 32'd1);
               chk("t2_pll_e20", 32'(pll_resetb), 32'd0);
    edges(20); chk("t2_retry2", 32'(retry_count), 32'd2);
    edges(19); chk("t2_fault_e59", 32'(fault), 32'd0);
    edges(1);  chk("t2_fault_e60", 32'(fault), 32'd1);
               chk("t2_pll_e60", 32'(pll_resetb), 32'd1);
               chk("t2_core_e60", 32'(core_reset), 32'd1);
    @(negedge clk); lock = 1'b1;
    edges(200); chk("t2_fault_hold", 32'(fault), 32'd1);
                chk("t2_ready_hold", 32'(ready), 32'd0);
                chk("t2_retry_hold", 32'(retry_count), 32'd2);

    // Test 5b: soft_relock out of FAULT.
    @(negedge clk); soft_relock = 1'b1;
    edges(1);  chk("t5_flt_fault", 32'(fault), 32'd0);
               chk("t5_flt_retry", 32'(retry_count), 32'd0);
               chk("t5_flt_pll", 32'(pll_resetb), 32'd0);
    @(negedge clk); soft_relock = 1'b0;
    edges(12); chk("t5_flt_ready12", 32'(ready), 32'd0);
    edges(1);  chk("t5_flt_ready13", 32'(ready), 32'd1);

    // Test 6b: reset while in FAULT.
    do_reset(1'b0);
    edges(60); chk("t6_flt_in", 32'(fault), 32'd1);
    @(negedge clk); reset = 1'b1;
    edges(1);  chk("t6_flt_fault", 32'(fault), 32'd0);
               chk("t6_flt_retry", 32'(retry_count), 32'd0);
               chk("t6_flt_pll", 32'(pll_resetb), 32'd0);
               chk("t6_flt_core", 32'(core_reset), 32'd1);
    @(negedge clk); reset = 1'b0;

    // Randomized phase: long lock runs with glitches, soft_relock pulses
    // and occasional resets, all judged by the model.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 29) == 0) lock = ~lock;
      soft_relock = ($urandom_range(0, 59) == 0);
      reset = ($urandom_range(0, 699) == 0);
    end
    @(negedge clk);
    reset = 1'b0;
    soft_relock = 1'b0;
    edges(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
